// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_cell register/delay-line family.
// Optional clock enable is selected with the DFF_CE_EN macro (see dff_cell).
`timescale 1ns/1ps
package dff_pkg;

  localparam int DFF_DEFAULT_WIDTH = 1;
  localparam int DFF_MAX_DEPTH     = 16;
  // Widest reset vector the helper below can describe.
  localparam int DFF_MAX_WIDTH     = 256;

  // Default reset vector for a register of the given width: all zeros,
  // with every bit above the requested width also forced to zero.
  function automatic logic [DFF_MAX_WIDTH-1:0] dff_default_reset(input int width);
    logic [DFF_MAX_WIDTH-1:0] mask;
    logic [DFF_MAX_WIDTH-1:0] one;
    one = {{(DFF_MAX_WIDTH-1){1'b0}}, 1'b1};
    if (width >= DFF_MAX_WIDTH) begin
      mask = '1;
    end else begin
      mask = (one << width) - one;
    end
    return '0 & mask;
  endfunction

endpackage

// File: rtl/dff_stage.sv
// Single WIDTH-bit register stage with asynchronous active-low reset to
// RESET_VAL and a clock enable (held high by the parent when unused).
`timescale 1ns/1ps
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(dff_default_reset(WIDTH))
) (
  input  logic             ck_i,
  input  logic             rb_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next state: take new data when enabled, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = d_i;
    end
  end

  // Storage: reset wins immediately, otherwise update on the rising edge.
  always_ff @(posedge ck_i or negedge rb_i) begin
    if (!rb_i) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/dff_cell.sv
// Rising-edge D register / fixed DEPTH-cycle delay line built from a chain of
// dff_stage instances. Q is driven straight from the last stage register.
// Define DFF_CE_EN to add the active-high clock enable port EN.
`timescale 1ns/1ps
module dff_cell
  import dff_pkg::*;
#(
  parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(dff_default_reset(WIDTH))
) (
  input  logic             CK,
  input  logic             RB,
`ifdef DFF_CE_EN
  input  logic             EN,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // A zero-stage or over-long chain is a configuration mistake.
  if (DEPTH < 1 || DEPTH > DFF_MAX_DEPTH) begin : g_bad_depth
    $fatal(1, "dff_cell: DEPTH=%0d outside 1..%0d", DEPTH, DFF_MAX_DEPTH);
  end

  logic en_w;

`ifdef DFF_CE_EN
  assign en_w = EN;
`else
  // Without the enable port every rising edge captures.
  assign en_w = 1'b1;
`endif

  // chain_w[0] is the input; chain_w[gi+1] is the output of stage gi.
  logic [WIDTH-1:0] chain_w [DEPTH+1];

  assign chain_w[0] = D;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .ck_i (CK),
      .rb_i (RB),
      .en_i (en_w),
      .d_i  (chain_w[gi]),
      .q_o  (chain_w[gi+1])
    );
  end

  assign Q = chain_w[DEPTH];

endmodule

// File: tb/tb_dff_cell.sv
// Directed bench for dff_cell: three instances (default 1-bit flop, 8-bit
// flop with reset value A5, 4-bit 3-deep delay line) sharing one clock.
// Expected values come from per-instance scoreboard queues.
`timescale 1ns/1ps
module tb_dff_cell;

  logic       ck   = 1'b0;
  logic       rb_a = 1'b1;
  logic       rb_b = 1'b1;
  logic       rb_c = 1'b1;
  logic       en_a = 1'b1;
  logic       en_b = 1'b1;
  logic       en_c = 1'b1;
  logic       d_a  = 1'b0;
  logic [7:0] d_b  = 8'h00;
  logic [3:0] d_c  = 4'h0;
  logic       q_a;
  logic [7:0] q_b;
  logic [3:0] q_c;

  dff_cell #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_a (
    .CK (ck),
    .RB (rb_a),
`ifdef DFF_CE_EN
    .EN (en_a),
`endif
    .D  (d_a),
    .Q  (q_a)
  );

  dff_cell #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5)) u_b (
    .CK (ck),
    .RB (rb_b),
`ifdef DFF_CE_EN
    .EN (en_b),
`endif
    .D  (d_b),
    .Q  (q_b)
  );

  dff_cell #(.WIDTH(4), .DEPTH(3), .RESET_VAL(4'hA)) u_c (
    .CK (ck),
    .RB (rb_c),
`ifdef DFF_CE_EN
    .EN (en_c),
`endif
    .D  (d_c),
    .Q  (q_c)
  );

  // Zero-width pulse at t=0, then rising edges at 10, 30, 50, ...
  initial begin
    ck = 1'b1;
    ck = 1'b0;
    forever begin
      #10 ck = 1'b1;
      #10 ck = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end expected end before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] sb_a [$];
  logic [7:0] sb_b [$];
  logic [7:0] sb_c [$];
  logic [7:0] exp_a = 8'h00;
  logic [7:0] exp_b = 8'hA5;
  logic [7:0] exp_c = 8'h0A;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic at(input time t);
    if (t > $time) #(t - $time);
  endtask

  task automatic reset_b();
    sb_b.delete();
    exp_b = 8'hA5;
  endtask

  task automatic reset_c();
    sb_c.delete();
    repeat (2) sb_c.push_back(8'h0A);
    exp_c = 8'h0A;
  endtask

  // One rising edge: push sampled D into each scoreboard, pop the value due
  // at Q, then compare all three outputs 1 ns later.
  task automatic edge_step();
    @(posedge ck);
    if (rb_a && en_a) begin
      sb_a.push_back({7'b0, d_a});
      exp_a = sb_a.pop_front();
    end
    if (rb_b && en_b) begin
      sb_b.push_back(d_b);
      exp_b = sb_b.pop_front();
    end
    if (rb_c && en_c) begin
      sb_c.push_back({4'b0, d_c});
      exp_c = sb_c.pop_front();
    end
    #1;
    check($sformatf("edge_a@%0t", $time), {7'b0, q_a}, exp_a);
    check($sformatf("edge_b@%0t", $time), q_b, exp_b);
    check($sformatf("edge_c@%0t", $time), {4'b0, q_c}, exp_c);
    $display("edge t=%0t a=%h/%h b=%h/%h c=%h/%h", $time, q_a, exp_a, q_b, exp_b, q_c, exp_c);
  endtask

  initial begin
    // Glitch capture at t=0 with D=0
    at(1);
    check("glitch_t0_a", {7'b0, q_a}, 8'h00);

    // Async reset of b and c, no clock involved
    at(2);
    rb_b = 1'b0;
    rb_c = 1'b0;
    reset_b();
    reset_c();
    at(3);
    check("rst_b", q_b, 8'hA5);
    check("rst_c", {4'b0, q_c}, 8'h0A);

    // Default-config timing plan on instance a
    edge_step();                       // 10
    at(24); d_a = 1'b1;
    at(29); check("plan_pre30_a", {7'b0, q_a}, 8'h00);
    edge_step();                       // 30
    check("plan_30_a", {7'b0, q_a}, 8'h01);
    at(48); d_a = 1'b0;
    edge_step();                       // 50
    check("plan_50_a", {7'b0, q_a}, 8'h00);
    edge_step();                       // 70
    check("plan_70_a", {7'b0, q_a}, 8'h00);
    at(72); d_a = 1'b1;
    edge_step();                       // 90
    check("plan_90_a", {7'b0, q_a}, 8'h01);
    at(96); d_a = 1'b0;
    edge_step();                       // 110
    check("plan_110_a", {7'b0, q_a}, 8'h00);

    // Release b and c, stream data
    at(115); rb_b = 1'b1; rb_c = 1'b1; d_b = 8'h11; d_c = 4'h1;
    edge_step();                       // 130
    at(135); d_b = 8'h22; d_c = 4'h2;
    edge_step();                       // 150
    at(155); d_c = 4'h3;
    edge_step();                       // 170
    check("lat3_first_c", {4'b0, q_c}, 8'h01);
    at(175); d_c = 4'h4;
    edge_step();                       // 190
    edge_step();                       // 210
    edge_step();                       // 230
    check("lat3_last_c", {4'b0, q_c}, 8'h04);

    // Mid-cycle reset pulse on b while Q is non-reset, then release
    at(235); rb_b = 1'b0; d_b = 8'h3C; reset_b();
    at(236); check("async_rst_b", q_b, 8'hA5);
    at(240); rb_b = 1'b1;
    at(241); check("no_early_b", q_b, 8'hA5);
    edge_step();                       // 250
    check("release_b", q_b, 8'h3C);

    // Mid-stream reset of the delay line; refill takes three edges
    at(255); rb_c = 1'b0; d_c = 4'h5; reset_c();
    at(256); check("midrst_c", {4'b0, q_c}, 8'h0A);
    at(260); rb_c = 1'b1;
    edge_step();                       // 270
    edge_step();                       // 290
    check("refill_wait_c", {4'b0, q_c}, 8'h0A);
    edge_step();                       // 310
    check("refill_c", {4'b0, q_c}, 8'h05);

    // Short D pulse strictly between edges must not reach Q
    at(311); d_a = 1'b1;
    at(315); d_c = 4'h6;
    at(328); d_a = 1'b0;
    at(329); check("dglitch_hold_a", {7'b0, q_a}, 8'h00);
    edge_step();                       // 330
    check("dglitch_edge_a", {7'b0, q_a}, 8'h00);

`ifdef DFF_CE_EN
    // Enable low: D keeps toggling, pipeline holds
    at(335); en_c = 1'b0;
    repeat (3) begin
      at($time + 4); d_c = d_c + 4'h1;
      edge_step();
    end
    check("en_hold_c", {4'b0, q_c}, 8'h05);
    // Enable high: pipeline resumes from where it stopped
    at($time + 4); en_c = 1'b1; d_c = 4'h9;
    edge_step();
    check("en_resume1_c", {4'b0, q_c}, 8'h05);
    edge_step();
    check("en_resume2_c", {4'b0, q_c}, 8'h06);
    edge_step();
    check("en_resume3_c", {4'b0, q_c}, 8'h09);
    // Reset still works with enable low
    at($time + 4); en_c = 1'b0; rb_c = 1'b0; reset_c();
    at($time + 1); check("en_rst_c", {4'b0, q_c}, 8'h0A);
    at($time + 4); rb_c = 1'b1; en_c = 1'b1;
    edge_step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
